serial_word_feeder: RTL and testbench

Parallel-to-serial front end for the right-shift register chain. Accepts a SIZE-bit word over a valid/ready handshake and emits it one bit per enabled cycle on `out` with a matching `out_enable` strobe. These two outputs wire directly to the downstream shift register's `in` and `enable`. After SIZE strobes, the downstream register holds the original word, bit 0 in bit 0, provided LSB_FIRST=1.

---
 rtl/serial_word_feeder.sv | 75 +++++++
 tb/tb_serial_word_feeder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder: takes a SIZE-bit word over valid/ready and emits it
// one bit per enabled cycle on out/out_enable for a downstream shift register.
module serial_word_feeder #(
    parameter int SIZE      = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SIZE-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            hold,
    output logic            out,
    output logic            out_enable,
    output logic            last,
    output logic            busy
);
    localparam int CW = $clog2(SIZE);
    localparam logic [CW-1:0] LAST_IDX = CW'(SIZE - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state, state_nxt;
    logic [SIZE-1:0] shadow, shadow_nxt;
    logic [CW-1:0]   count, count_nxt;
    logic            accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            shadow <= '0;
            count  <= '0;
        end else begin
            state  <= state_nxt;
            shadow <= shadow_nxt;
            count  <= count_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        count_nxt  = count;
        busy       = 1'b0;
        out        = 1'b0;
        out_enable = 1'b0;
        last       = 1'b0;
        in_ready   = 1'b1;
        accept     = 1'b0;

        case (state)
            SHIFT: begin
                busy       = 1'b1;
                out        = LSB_FIRST ? shadow[0] : shadow[SIZE-1];
                out_enable = !hold;
                last       = out_enable && (count == LAST_IDX);
                // Ready only while the final bit retires, so a new word lands with no bubble.
                in_ready   = last;
            end
            default: ;
        endcase

        accept = in_valid && in_ready;

        if (accept) begin
            shadow_nxt = in_data;
            count_nxt  = '0;
            state_nxt  = SHIFT;
        end else if (out_enable) begin
            shadow_nxt = LSB_FIRST ? (shadow >> 1) : (shadow << 1);
            count_nxt  = count + CW'(1);
            if (last) state_nxt = IDLE;
        end
    end
endmodule

// File: tb/tb_serial_word_feeder.sv
// Scoreboard bench: accepted words expand into expected bit streams; monitors
// compare every cycle's outputs against the queue heads for two configurations.
module tb_serial_word_feeder;
    typedef struct {
        logic       b;
        logic       l;
        logic [7:0] w;
    } ent_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_data8 = '0;
    logic       in_valid8 = 1'b0, hold8 = 1'b0;
    logic       in_ready8, out8, oe8, last8, busy8;
    logic [3:0] in_data4 = '0;
    logic       in_valid4 = 1'b0, hold4 = 1'b0;
    logic       in_ready4, out4, oe4, last4, busy4;

    int total = 0;
    int bad = 0;
    ent_t q8[$];
    ent_t q4[$];
    logic [7:0] sr8 = '0;
    logic [7:0] pword8;
    logic       pend8 = 1'b0;
    logic       done8, done4;

    serial_word_feeder #(.SIZE(8), .LSB_FIRST(1'b1)) dut8 (
        .clk(clk), .reset(reset), .in_data(in_data8), .in_valid(in_valid8),
        .in_ready(in_ready8), .hold(hold8), .out(out8), .out_enable(oe8),
        .last(last8), .busy(busy8));

    serial_word_feeder #(.SIZE(4), .LSB_FIRST(1'b0)) dut4 (
        .clk(clk), .reset(reset), .in_data(in_data4), .in_valid(in_valid4),
        .in_ready(in_ready4), .hold(hold4), .out(out4), .out_enable(oe4),
        .last(last4), .busy(busy4));

    always #5 clk = ~clk;

    // Stand-in for the downstream right-shift register: new bit enters at the MSB.
    always @(posedge clk) if (oe8) sr8 <= {out8, sr8[7:1]};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic void push_word(ref ent_t q[$], input logic [7:0] w, input int size, input bit lsb);
        for (int i = 0; i < size; i++) begin
            ent_t e;
            e.b = w[lsb ? i : size - 1 - i];
            e.l = (i == size - 1);
            e.w = w;
            q.push_back(e);
        end
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            q8.delete();
            pend8 = 1'b0;
            chk("rst8_ready", in_ready8, 1);
            chk("rst8_outs", {out8, oe8, last8, busy8}, 0);
        end else begin
            logic bz, oe, lst, rdy;
            if (pend8) begin
                chk("downstream8", sr8, pword8);
                pend8 = 1'b0;
            end
            bz  = (q8.size() != 0);
            oe  = bz && !hold8;
            lst = oe && q8[0].l;
            rdy = !bz || lst;
            chk("busy8", busy8, bz);
            chk("oe8", oe8, oe);
            chk("last8", last8, lst);
            chk("ready8", in_ready8, rdy);
            chk("out8", out8, bz ? q8[0].b : 1'b0);
            if (oe) begin
                ent_t e;
                e = q8.pop_front();
                if (e.l) begin
                    pend8  = 1'b1;
                    pword8 = e.w;
                end
            end
            if (in_valid8 && rdy) push_word(q8, in_data8, 8, 1'b1);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            q4.delete();
            chk("rst4_ready", in_ready4, 1);
            chk("rst4_outs", {out4, oe4, last4, busy4}, 0);
        end else begin
            logic bz, oe, lst, rdy;
            bz  = (q4.size() != 0);
            oe  = bz && !hold4;
            lst = oe && q4[0].l;
            rdy = !bz || lst;
            chk("busy4", busy4, bz);
            chk("oe4", oe4, oe);
            chk("last4", last4, lst);
            chk("ready4", in_ready4, rdy);
            chk("out4", out4, bz ? q4[0].b : 1'b0);
            if (oe) void'(q4.pop_front());
            if (in_valid4 && rdy) push_word(q4, {4'b0, in_data4}, 4, 1'b0);
        end
    end

    // Returns one cycle-phase after the accepting edge, in_valid still high.
    task automatic send8(input logic [7:0] w);
        int n = 0;
        logic acc;
        in_valid8 = 1'b1;
        in_data8  = w;
        do begin
            @(negedge clk);
            acc = in_ready8;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 300);
        if (!acc) chk("accept8_timeout", 0, 1);
    endtask

    task automatic send4(input logic [3:0] w);
        int n = 0;
        logic acc;
        in_valid4 = 1'b1;
        in_data4  = w;
        do begin
            @(negedge clk);
            acc = in_ready4;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 300);
        if (!acc) chk("accept4_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q8.size() != 0 || q4.size() != 0) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", (q8.size() != 0 || q4.size() != 0), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #12 reset = 1'b1;
        @(posedge clk);
        #1;

        // Single word, then back-to-back pair.
        send8(8'hB4);
        in_valid8 = 1'b0;
        wait_idle();
        send8(8'hB4);
        send8(8'h5A);
        in_valid8 = 1'b0;
        wait_idle();

        // Hold three cycles after the 4th bit.
        send8(8'hFF);
        in_valid8 = 1'b0;
        repeat (4) @(posedge clk);
        #1 hold8 = 1'b1;
        repeat (3) @(posedge clk);
        #1 hold8 = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (last8) begin
                n = i;
                break;
            end
        end
        chk("hold_last_delay", n, 4);
        wait_idle();

        // Backpressure with a data change before accept.
        send8(8'h3C);
        in_data8 = 8'hAA;
        repeat (2) @(posedge clk);
        #1;
        send8(8'h0F);
        in_valid8 = 1'b0;
        wait_idle();

        // Reset mid-word.
        send8(8'hC3);
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_now8", {in_ready8, out8, oe8, last8, busy8}, 5'b10000);
        chk("rst_now4", {in_ready4, out4, oe4, last4, busy4}, 5'b10000);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        send8(8'h81);
        in_valid8 = 1'b0;
        wait_idle();

        // MSB-first narrow instance.
        send4(4'b1100);
        in_valid4 = 1'b0;
        wait_idle();

        // Randomized traffic with random stalls on both instances.
        done8 = 1'b0;
        done4 = 1'b0;
        fork
            begin
                for (int k = 0; k < 120; k++) begin
                    int g;
                    g = $urandom_range(0, 2);
                    if (g != 0) begin
                        in_valid8 = 1'b0;
                        repeat (g) begin @(posedge clk); #1; end
                    end
                    send8(8'($urandom));
                end
                in_valid8 = 1'b0;
                done8 = 1'b1;
            end
            begin
                while (!done8) begin
                    @(posedge clk);
                    #1 hold8 = ($urandom_range(0, 3) == 0);
                end
                hold8 = 1'b0;
            end
            begin
                for (int k = 0; k < 120; k++) begin
                    int g;
                    g = $urandom_range(0, 2);
                    if (g != 0) begin
                        in_valid4 = 1'b0;
                        repeat (g) begin @(posedge clk); #1; end
                    end
                    send4(4'($urandom));
                end
                in_valid4 = 1'b0;
                done4 = 1'b1;
            end
            begin
                while (!done4) begin
                    @(posedge clk);
                    #1 hold4 = ($urandom_range(0, 3) == 0);
                end
                hold4 = 1'b0;
            end
        join
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
